uart_tx_port: RTL and testbench

Memory-mapped UART transmitter that is the peripheral side of the CPU's UART Tx registers. It accepts data-register writes (0x10010034) and send-register writes (0x1001003C) already decoded by the memory-map controller. It serializes one 8-bit frame per send request on the `tx` line. It also returns the send-register status and the STOP-state flag for CPU polling.

---
 rtl/uart_tx_port_pkg.sv | 22 ++
 rtl/uart_tx_port_if.sv | 25 ++
 rtl/uart_tx_port_baud_tick.sv | 37 +++
 rtl/uart_tx_port.sv | 147 ++++++++++++++
 tb/tb_uart_tx_port.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_port_pkg.sv
// UART_pkg: shared types and constants for the UART transmit path.
//   tx_state_t     - transmitter FSM encoding
//   UART_DATA_BITS - payload bits per frame
//   UART_IDLE_LEVEL- line level while idle / during STOP
// Optional feature macro used by users of this package: UART_TX_PARITY_EN.
package UART_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam int unsigned UART_BIT_IDX_W  = $clog2(UART_DATA_BITS);
   localparam logic        UART_IDLE_LEVEL = 1'b1;

   typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: CPU-side register strobes and status of the UART Tx port.
//   master : memory-map controller (drives write strobes, reads status/line)
//   slave  : uart_tx_port (receives strobes, drives tx and status)
interface uart_tx_port_if;

   logic                  tx_data_en;
   UART_pkg::uart_byte_t  Tx_Data_w;
   logic                  tx_send_en;
   logic                  tx_send;
   logic                  tx;
   logic                  tx_send_reg;
   logic                  tx_fsm_in_STOP_S;
   logic                  tx_busy;

   modport master (
      output tx_data_en, Tx_Data_w, tx_send_en, tx_send,
      input  tx, tx_send_reg, tx_fsm_in_STOP_S, tx_busy
   );

   modport slave (
      input  tx_data_en, Tx_Data_w, tx_send_en, tx_send,
      output tx, tx_send_reg, tx_fsm_in_STOP_S, tx_busy
   );

endinterface

// File: rtl/uart_tx_port_baud_tick.sv
// uart_baud_tick: bit-period counter shared by the UART Tx FSM and Rx sampler.
//   clk, rst (sync, active-high), en : counter runs only while en=1, else held at 0
//   tick                             : one-cycle pulse on the terminal count
//                                      (CLKS_PER_BIT-1); counter wraps to 0 there
// CLKS_PER_BIT must be >= 2.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;

   // tick is registered one count early so it coincides with the terminal count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (!en) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) r_cnt <= '0;
         else                                   r_cnt <= r_cnt + CNT_W'(1);
         r_tick <= (r_cnt == CNT_W'(CLKS_PER_BIT - 2));
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter (data reg 0x10010034, send reg 0x1001003C).
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : tx_data_en/Tx_Data_w load the data register,
//                       tx_send_en/tx_send set the send register,
//                       tx (serial line, LSB first), tx_send_reg, tx_fsm_in_STOP_S, tx_busy
// Frame is 8N1; defining UART_TX_PARITY_EN inserts an even-parity bit before STOP.
module uart_tx_port
   import UART_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE = 115200
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_port_if.slave   bus
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

   tx_state_t                 r_state,   w_state_nxt;
   uart_byte_t                r_data;
   uart_byte_t                r_shift,   w_shift_nxt;
   logic [UART_BIT_IDX_W-1:0] r_bit_idx, w_bit_idx_nxt;
   logic                      r_send,    w_send_nxt;
   logic                      r_tx,      w_tx_nxt;
   logic                      r_busy;
   logic                      r_in_stop;
   logic                      w_tick;
   logic                      w_baud_en;
`ifdef UART_TX_PARITY_EN
   logic                      r_parity,  w_parity_nxt;
`endif

   assign w_baud_en = (r_state != IDLE);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (w_baud_en),
      .tick (w_tick)
   );

   // State and datapath registers; status outputs follow the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_data    <= '0;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_send    <= 1'b0;
         r_tx      <= UART_IDLE_LEVEL;
         r_busy    <= 1'b0;
         r_in_stop <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         if (bus.tx_data_en) r_data <= bus.Tx_Data_w;
         r_shift   <= w_shift_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_send    <= w_send_nxt;
         r_tx      <= w_tx_nxt;
         r_busy    <= (w_state_nxt != IDLE);
         r_in_stop <= (w_state_nxt == STOP);
`ifdef UART_TX_PARITY_EN
         r_parity  <= w_parity_nxt;
`endif
      end
   end

   // Next-state, send-register and line-level logic
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_idx_nxt = r_bit_idx;
      w_send_nxt    = r_send;
      w_tx_nxt      = UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt  = r_parity;
`endif

      // no queue: a request while one is pending or active is dropped
      if (bus.tx_send_en && bus.tx_send && !r_send) w_send_nxt = 1'b1;

      case (r_state)
         IDLE: begin
            if (r_send) begin
               w_state_nxt   = START;
               w_shift_nxt   = r_data;
               w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
               w_parity_nxt  = ^r_data;
`endif
            end
         end
         START: begin
            if (w_tick) w_state_nxt = DATA;
         end
         DATA: begin
            if (w_tick) begin
               w_shift_nxt = r_shift >> 1;
               if (r_bit_idx == LAST_BIT) begin
                  w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_nxt   = PARITY;
`else
                  w_state_nxt   = STOP;
`endif
               end else begin
                  w_bit_idx_nxt = r_bit_idx + UART_BIT_IDX_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_tick) w_state_nxt = STOP;
         end
`endif
         STOP: begin
            if (w_tick) begin
               w_state_nxt = IDLE;
               w_send_nxt  = 1'b0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      case (w_state_nxt)
         START:   w_tx_nxt = ~UART_IDLE_LEVEL;
         DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_tx_nxt = w_parity_nxt;
`endif
         default: w_tx_nxt = UART_IDLE_LEVEL;
      endcase
   end

   assign bus.tx               = r_tx;
   assign bus.tx_send_reg      = r_send;
   assign bus.tx_fsm_in_STOP_S = r_in_stop;
   assign bus.tx_busy          = r_busy;

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: scoreboard bench for uart_tx_port (CLKS_PER_BIT=4).
// Honours UART_TX_PARITY_EN for the expected frame format.
module tb_uart_tx_port;

   localparam int unsigned CLK_FREQ  = 400;
   localparam int unsigned BAUD_RATE = 100;
   localparam int unsigned CPB       = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
`else
   localparam int unsigned FRAME_BITS = 10;
`endif
   localparam int unsigned FRAME_LEN = FRAME_BITS * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   uart_tx_port_if bus ();

   uart_tx_port #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned n_checks    = 0;
   int unsigned n_pass      = 0;
   int unsigned frames_seen = 0;
   logic [7:0]  exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
   endtask

   task automatic check_frame(input logic [FRAME_BITS-1:0] bits);
      logic [7:0] exp;
      frames_seen++;
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         check_eq("start_bit", 32'(bits[0]), 32'd0);
         check_eq("frame_data", 32'(bits[8:1]), 32'(exp));
`ifdef UART_TX_PARITY_EN
         check_eq("parity_bit", 32'(bits[9]), 32'(^exp));
`endif
         check_eq("stop_bit", 32'(bits[FRAME_BITS-1]), 32'd1);
      end
   endtask

   // Line monitor: decode frames mid-bit, measure status pulse lengths
   bit                    mon_in_frame = 1'b0;
   int unsigned           mon_cyc      = 0;
   logic [FRAME_BITS-1:0] mon_bits     = '0;
   int unsigned           busy_cnt     = 0;
   int unsigned           stop_cnt     = 0;
   int unsigned           send_cnt     = 0;

   always @(negedge clk) begin
      if (rst) begin
         mon_in_frame = 1'b0;
         mon_cyc      = 0;
         busy_cnt     = 0;
         stop_cnt     = 0;
         send_cnt     = 0;
      end else begin
         if (!mon_in_frame && bus.tx == 1'b0) begin
            mon_in_frame = 1'b1;
            mon_cyc      = 0;
         end
         if (mon_in_frame) begin
            if (mon_cyc % CPB == CPB / 2) mon_bits = {bus.tx, mon_bits[FRAME_BITS-1:1]};
            mon_cyc++;
            if (mon_cyc == FRAME_LEN) begin
               mon_in_frame = 1'b0;
               check_frame(mon_bits);
            end
         end
         if (bus.tx_busy) busy_cnt++;
         else if (busy_cnt != 0) begin
            check_eq("busy_len", busy_cnt, FRAME_LEN);
            busy_cnt = 0;
         end
         if (bus.tx_fsm_in_STOP_S) stop_cnt++;
         else if (stop_cnt != 0) begin
            check_eq("stop_len", stop_cnt, CPB);
            stop_cnt = 0;
         end
         if (bus.tx_send_reg) send_cnt++;
         else if (send_cnt != 0) begin
            check_eq("send_reg_len", send_cnt, FRAME_LEN + 1);
            send_cnt = 0;
         end
      end
   end

   task automatic write_data(input logic [7:0] b);
      bus.tx_data_en = 1'b1;
      bus.Tx_Data_w  = b;
      @(negedge clk);
      bus.tx_data_en = 1'b0;
   endtask

   task automatic send_req();
      bus.tx_send_en = 1'b1;
      bus.tx_send    = 1'b1;
      @(negedge clk);
      bus.tx_send_en = 1'b0;
      bus.tx_send    = 1'b0;
   endtask

   // Request a frame of b (optionally writing b in the same cycle) and check start timing
   task automatic start_frame(input logic [7:0] b, input bit with_data);
      if (with_data) begin
         bus.tx_data_en = 1'b1;
         bus.Tx_Data_w  = b;
      end
      exp_q.push_back(b);
      send_req();
      bus.tx_data_en = 1'b0;
      check_eq("send_reg_set", 32'(bus.tx_send_reg), 32'd1);
      check_eq("tx_before_start", 32'(bus.tx), 32'd1);
      @(negedge clk);
      check_eq("tx_start", 32'(bus.tx), 32'd0);
      check_eq("busy_start", 32'(bus.tx_busy), 32'd1);
   endtask

   task automatic wait_idle();
      int unsigned k = 0;
      while (bus.tx_busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      check_eq("frame_done", 32'(bus.tx_busy), 32'd0);
      check_eq("send_reg_clear", 32'(bus.tx_send_reg), 32'd0);
   endtask

   initial begin
      bus.tx_data_en = 1'b0;
      bus.Tx_Data_w  = '0;
      bus.tx_send_en = 1'b0;
      bus.tx_send    = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_tx", 32'(bus.tx), 32'd1);
      check_eq("rst_send_reg", 32'(bus.tx_send_reg), 32'd0);
      check_eq("rst_stop", 32'(bus.tx_fsm_in_STOP_S), 32'd0);
      check_eq("rst_busy", 32'(bus.tx_busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // basic frame
      write_data(8'hA5);
      start_frame(8'hA5, 1'b0);
      wait_idle();

      // data write during bit 3 must not disturb the active frame
      write_data(8'hA5);
      start_frame(8'hA5, 1'b0);
      repeat (16) @(negedge clk);
      write_data(8'h3C);
      wait_idle();
      start_frame(8'h3C, 1'b0);
      wait_idle();

      // send request while busy is dropped
      write_data(8'h96);
      start_frame(8'h96, 1'b0);
      repeat (10) @(negedge clk);
      send_req();
      wait_idle();
      repeat (20) @(negedge clk);
      check_eq("no_second_frame", 32'(bus.tx_busy), 32'd0);

      // simultaneous data and send strobes
      start_frame(8'h5A, 1'b1);
      wait_idle();

      // back-to-back frames
      start_frame(8'h81, 1'b1);
      wait_idle();
      start_frame(8'hC3, 1'b1);
      wait_idle();

      // odd-weight byte (parity 1 when enabled)
      start_frame(8'h07, 1'b1);
      wait_idle();

      // reset during DATA aborts the frame and clears the data register
      start_frame(8'hF0, 1'b1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_eq("midrst_tx", 32'(bus.tx), 32'd1);
      check_eq("midrst_busy", 32'(bus.tx_busy), 32'd0);
      check_eq("midrst_send_reg", 32'(bus.tx_send_reg), 32'd0);
      check_eq("midrst_stop", 32'(bus.tx_fsm_in_STOP_S), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      start_frame(8'h00, 1'b0);
      wait_idle();

      repeat (10) @(negedge clk);
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      check_eq("frames_seen", frames_seen, 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
